fc_result_collector: RTL and testbench
======================================

// Module: fc_result_collector
// PURPOSE
//  Consumer end of the fully-connected node stream: captures one IEEE-754 result per
//  i_valid pulse from the FC node(s) until NUMBER_OUTPUT_NODE results are held, tracks
//  the raw argmax (class index), then replays the vector with optional ReLU to the next
//  layer over a valid/ready handshake. Sits between an FC layer and the next layer/classifier.
// PARAMETERS
//  DATA_WIDTH          32   float word width (IEEE-754 single; sign = bit DATA_WIDTH-1)
//  NUMBER_OUTPUT_NODE  10   results per vector (>=2)
//  RELU_EN             1    1: negative words (sign=1) replaced by +0 on o_data; 0: pass-through
//  INDEX_WIDTH   $clog2(NUMBER_OUTPUT_NODE)  localparam, counter/class width
// PORTS
//  clk            in   1            clock, all state on posedge
//  rst_n          in   1            asynchronous active-low reset
//  i_valid        in   1            one result present on i_data this cycle
//  i_data         in   DATA_WIDTH   FC node result, indices arrive in order 0..N-1
//  i_ready        in   1            downstream accepts o_data this cycle
//  o_data         out  DATA_WIDTH   buffered word (ReLU applied if RELU_EN)
//  o_valid        out  1            o_data valid; held until accepted
//  o_last         out  1            high with o_valid on index N-1
//  o_class        out  INDEX_WIDTH  argmax index of raw (pre-ReLU) vector
//  o_class_valid  out  1            one-cycle pulse, o_class updated
//  o_busy         out  1            high in DRAIN
//  o_overflow     out  1            sticky: i_valid arrived while DRAIN
// BEHAVIOUR
//  Reset (async, rst_n=0): state=COLLECT, wr_cnt=rd_cnt=0, o_valid=o_last=0, o_data=0,
//   o_class=0, o_class_valid=0, o_busy=0, o_overflow=0, max_key cleared. Buffer not reset.
//   Reset mid-vector or mid-drain discards partial vector; no output after release until
//   N fresh results.
//  COLLECT: on i_valid write buf[wr_cnt]<=i_data, wr_cnt++. Compare key(i_data) vs max_key:
//   wr_cnt==0 loads unconditionally; else update max/index only if strictly greater (ties ->
//   lowest index). key(x) = x[MSB] ? ~x : x ^ (1<<MSB); unsigned compare. NaN unsupported.
//   On i_valid with wr_cnt==N-1: next cycle state=DRAIN, o_busy=1, o_valid=1 (rd_cnt=0),
//   o_class=final argmax, o_class_valid=1 for exactly that cycle, wr_cnt<=0.
//   Latency: N-th i_valid at cycle t -> o_valid/o_class_valid at t+1.
//  DRAIN: o_data=relu(buf[rd_cnt]) while o_valid; o_data=0 whenever o_valid=0.
//   Transfer = o_valid & i_ready -> rd_cnt++; o_data/o_last stable while i_ready low.
//   o_last = (rd_cnt==N-1). Transfer with o_last: next cycle state=COLLECT, o_valid=0,
//   o_busy=0, rd_cnt=0. Back-to-back vectors: first i_valid of next vector accepted the
//   cycle after last transfer (1 bubble min).
//  i_valid during DRAIN (including the cycle of the last transfer): word dropped,
//   o_overflow<=1 and held until reset; buffer and argmax unaffected.
//  ReLU: sign=1 -> 32'h0 (+0); -0 (32'h8000_0000) also -> +0. Argmax always uses raw value.
// STRUCTURE
//  fc_pkg: DATA_WIDTH default, FP_SIGN_BIT, state enc (ST_COLLECT, ST_DRAIN), fp_order_key func.
//  Sub-module fp_compare_gt (a,b -> a>b via order key); buffer as reg array, 2-state FSM, cnts.
// TESTING
//  N=4,RELU_EN=1, in {3F800000,C0000000,40400000,40400000}, i_ready=1 -> o_data
//   {3F800000,00000000,40400000,40400000}, o_last on 4th, o_class=2 (tie -> lower), pulse once.
//  All negative {BF800000,C0000000,BF000000,C0400000} -> o_class=2, all o_data=0; RELU_EN=0 raw.
//  i_ready low 3 cycles on index 1 -> o_data held 00000000/... stable, no skip, no duplicate.
//  i_valid during DRAIN -> o_overflow=1 sticky, drained vector unchanged, next vector from 0.
//  rst_n low after 2 of 4 inputs, release, send 4 new -> output is only the new vector, timing t+1.
//  Two vectors back-to-back with 1-cycle gap after last transfer -> both drained, no overflow.

Source files
------------

// File: rtl/fc_result_collector_pkg.sv
// Shared types and helpers for the FC result collector.
package fc_result_collector_pkg;

    // IEEE-754 single precision word layout.
    localparam int unsigned FP_DATA_WIDTH = 32;
    localparam int unsigned FP_SIGN_BIT   = FP_DATA_WIDTH - 1;

    // Collector FSM: gather a vector, then replay it downstream.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_e;

    // Map a float onto an unsigned key whose integer order matches float order.
    // Negatives are inverted so a larger magnitude gives a smaller key. Positives
    // get the sign bit set so they sort above every negative. NaN is not ordered.
    function automatic logic [FP_DATA_WIDTH-1:0] fp_order_key(
        input logic [FP_DATA_WIDTH-1:0] x
    );
        logic [FP_DATA_WIDTH-1:0] sign_mask;
        sign_mask = '0;
        sign_mask[FP_SIGN_BIT] = 1'b1;
        fp_order_key = x[FP_SIGN_BIT] ? ~x : (x ^ sign_mask);
    endfunction

endpackage

// File: rtl/fc_result_collector_fp_compare_gt.sv
// Strict greater-than compare of two floats using the order-key mapping.
module fc_result_collector_fp_compare_gt
    import fc_result_collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FP_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  a_gt_b_o
);

    logic [DATA_WIDTH-1:0] key_a;
    logic [DATA_WIDTH-1:0] key_b;

    if (DATA_WIDTH == FP_DATA_WIDTH) begin : g_pkg_key
        assign key_a = fp_order_key(a_i);
        assign key_b = fp_order_key(b_i);
    end else begin : g_generic_key
        // Same mapping as fp_order_key, for a non-single-precision word size.
        localparam logic [DATA_WIDTH-1:0] SIGN_MASK = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
        assign key_a = a_i[DATA_WIDTH-1] ? ~a_i : (a_i ^ SIGN_MASK);
        assign key_b = b_i[DATA_WIDTH-1] ? ~b_i : (b_i ^ SIGN_MASK);
    end

    // Unsigned key order equals float order, ties are not greater.
    assign a_gt_b_o = (key_a > key_b);

endmodule

// File: rtl/fc_result_collector.sv
// Collects one FC result vector, tracks its argmax, then replays it (optional ReLU)
// to the next layer over a valid/ready handshake.
module fc_result_collector
    import fc_result_collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = FP_DATA_WIDTH,
    parameter int unsigned NUMBER_OUTPUT_NODE = 10,
    parameter int unsigned RELU_EN            = 1,
    localparam int unsigned INDEX_WIDTH       = $clog2(NUMBER_OUTPUT_NODE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    output logic                   o_last,
    output logic [INDEX_WIDTH-1:0] o_class,
    output logic                   o_class_valid,
    output logic                   o_busy,
    output logic                   o_overflow
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUMBER_OUTPUT_NODE - 1);

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [INDEX_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [DATA_WIDTH-1:0]  max_val_q, max_val_d;
    logic [INDEX_WIDTH-1:0] max_idx_q, max_idx_d;
    logic [INDEX_WIDTH-1:0] class_q, class_d;
    logic                   class_valid_q, class_valid_d;
    logic                   overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]  buf_q [NUMBER_OUTPUT_NODE];
    logic                   buf_we;

    logic                   in_gt_max;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0]  relu_word;

    // Raw incoming word versus the running maximum of the current vector.
    fc_result_collector_fp_compare_gt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_compare_gt (
        .a_i      (i_data),
        .b_i      (max_val_q),
        .a_gt_b_o (in_gt_max)
    );

    // Next-state logic for the collect/drain FSM, counters, argmax and flags.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
        class_d       = class_q;
        class_valid_d = 1'b0;
        overflow_d    = overflow_q;
        buf_we        = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                if (i_valid) begin
                    buf_we = 1'b1;
                    // First word seeds the max; later words must be strictly greater,
                    // so ties resolve to the lowest index.
                    if ((wr_cnt_q == '0) || in_gt_max) begin
                        max_val_d = i_data;
                        max_idx_d = wr_cnt_q;
                    end
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d       = ST_DRAIN;
                        wr_cnt_d      = '0;
                        rd_cnt_d      = '0;
                        class_valid_d = 1'b1;
                        // Fold in the final word directly so the class is ready at t+1.
                        class_d       = in_gt_max ? wr_cnt_q : max_idx_q;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Upstream is not allowed to push while we replay; record and drop.
                if (i_valid) begin
                    overflow_d = 1'b1;
                end
                if (i_ready) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d  = ST_COLLECT;
                        rd_cnt_d = '0;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    // Result buffer; contents are only observed after a full vector is written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_cnt_q] <= i_data;
        end
    end

    // Output word: ReLU maps any sign-set word (including -0) to +0.
    always_comb begin
        rd_word   = buf_q[rd_cnt_q];
        relu_word = rd_word;
        if ((RELU_EN != 0) && rd_word[DATA_WIDTH-1]) begin
            relu_word = '0;
        end
        o_data = (state_q == ST_DRAIN) ? relu_word : '0;
    end

    assign o_valid       = (state_q == ST_DRAIN);
    assign o_busy        = (state_q == ST_DRAIN);
    assign o_last        = (state_q == ST_DRAIN) && (rd_cnt_q == LAST_IDX);
    assign o_class       = class_q;
    assign o_class_valid = class_valid_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_fc_result_collector.sv
// Bench for fc_result_collector: a queue-based vector model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_fc_result_collector;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;

    logic [31:0] o_data_r, o_data_w;
    logic        o_valid_r, o_valid_w, o_last_r, o_last_w;
    logic [1:0]  o_class_r, o_class_w;
    logic        o_cv_r, o_cv_w, o_busy_r, o_busy_w, o_ovf_r, o_ovf_w;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fc_result_collector #(
        .DATA_WIDTH (32), .NUMBER_OUTPUT_NODE (N), .RELU_EN (1)
    ) dut_relu (
        .clk (clk), .rst_n (rst_n), .i_valid (i_valid), .i_data (i_data),
        .i_ready (i_ready), .o_data (o_data_r), .o_valid (o_valid_r), .o_last (o_last_r),
        .o_class (o_class_r), .o_class_valid (o_cv_r), .o_busy (o_busy_r),
        .o_overflow (o_ovf_r)
    );

    fc_result_collector #(
        .DATA_WIDTH (32), .NUMBER_OUTPUT_NODE (N), .RELU_EN (0)
    ) dut_raw (
        .clk (clk), .rst_n (rst_n), .i_valid (i_valid), .i_data (i_data),
        .i_ready (i_ready), .o_data (o_data_w), .o_valid (o_valid_w), .o_last (o_last_w),
        .o_class (o_class_w), .o_class_valid (o_cv_w), .o_busy (o_busy_w),
        .o_overflow (o_ovf_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int argmax(input logic [31:0] q[$]);
        int best = 0;
        for (int i = 1; i < q.size(); i++) if (fp_gt(q[i], q[best])) best = i;
        return best;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] w);
        return w[31] ? 32'h0 : w;
    endfunction

    logic [31:0] col_q[$];
    logic [31:0] drn_q[$];
    bit          m_ovf   = 1'b0;
    int          m_class = 0;
    bit          m_pulse = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q.delete();
            drn_q.delete();
            m_ovf   = 1'b0;
            m_class = 0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (drn_q.size() > 0) begin
                if (i_valid) m_ovf = 1'b1;
                if (i_ready) void'(drn_q.pop_front());
            end else if (i_valid) begin
                col_q.push_back(i_data);
                if (col_q.size() == N) begin
                    drn_q   = col_q;
                    col_q.delete();
                    m_class = argmax(drn_q);
                    m_pulse = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] raw;
        ev  = (drn_q.size() > 0);
        raw = ev ? drn_q[0] : 32'h0;
        check("o_valid",        32'(o_valid_r), 32'(ev));
        check("o_busy",         32'(o_busy_r),  32'(ev));
        check("o_data_relu",    o_data_r,       relu(raw));
        check("o_last",         32'(o_last_r),  32'(drn_q.size() == 1));
        check("o_class",        32'(o_class_r), 32'(m_class));
        check("o_class_valid",  32'(o_cv_r),    32'(m_pulse));
        check("o_overflow",     32'(o_ovf_r),   32'(m_ovf));
        check("raw_o_valid",    32'(o_valid_w), 32'(ev));
        check("raw_o_busy",     32'(o_busy_w),  32'(ev));
        check("raw_o_data",     o_data_w,       raw);
        check("raw_o_last",     32'(o_last_w),  32'(drn_q.size() == 1));
        check("raw_o_class",    32'(o_class_w), 32'(m_class));
        check("raw_o_cv",       32'(o_cv_w),    32'(m_pulse));
        check("raw_o_overflow", 32'(o_ovf_w),   32'(m_ovf));
    end

    // ---------------- transfer monitor ----------------
    logic [31:0] got_r[$];
    logic [31:0] got_w[$];
    logic [31:0] cls_q[$];
    logic [31:0] last_q[$];

    always @(negedge clk) begin
        if (o_valid_r && i_ready) begin
            got_r.push_back(o_data_r);
            if (o_last_r) last_q.push_back(32'(got_r.size()));
        end
        if (o_valid_w && i_ready) got_w.push_back(o_data_w);
        if (o_cv_r) cls_q.push_back(32'(o_class_r));
    end

    task automatic clear_mon();
        got_r.delete();
        got_w.delete();
        cls_q.delete();
        last_q.delete();
    endtask

    task automatic check_vec(input string name, input logic [31:0] got[$],
                             input logic [31:0] exp[$]);
        check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [31:0] v[$]);
        foreach (v[i]) begin
            i_valid = 1'b1;
            i_data  = v[i];
            step();
        end
        i_valid = 1'b0;
        i_data  = 32'h0;
    endtask

    logic [31:0] vec_a[$], vec_n[$], vec_b[$], vec_d[$], exp_q[$];

    initial begin
        i_valid = 1'b0;
        i_data  = 32'h0;
        i_ready = 1'b1;
        vec_a = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40400000};
        vec_n = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000};
        vec_b = '{32'h40000000, 32'h3F000000, 32'hC1000000, 32'h41000000};
        vec_d = '{32'h3F800000, 32'h40A00000, 32'h40000000, 32'hC0800000};

        #1 rst_n = 1'b0;
        step();
        step();
        check("reset_o_valid",    32'(o_valid_r), 32'h0);
        check("reset_o_data",     o_data_r,       32'h0);
        check("reset_o_class",    32'(o_class_r), 32'h0);
        check("reset_o_overflow", 32'(o_ovf_r),   32'h0);
        rst_n = 1'b1;
        step();

        // Mixed signs with a tie at the maximum.
        clear_mon();
        send_vec(vec_a);
        repeat (6) step();
        exp_q = '{32'h3F800000, 32'h00000000, 32'h40400000, 32'h40400000};
        check_vec("a_relu", got_r, exp_q);
        check_vec("a_raw", got_w, vec_a);
        exp_q = '{32'd2};
        check_vec("a_class", cls_q, exp_q);
        exp_q = '{32'd4};
        check_vec("a_last", last_q, exp_q);

        // All negative inputs.
        clear_mon();
        send_vec(vec_n);
        repeat (6) step();
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0};
        check_vec("n_relu", got_r, exp_q);
        check_vec("n_raw", got_w, vec_n);
        exp_q = '{32'd2};
        check_vec("n_class", cls_q, exp_q);

        // Downstream stall on index 1.
        clear_mon();
        send_vec(vec_a);
        step();
        i_ready = 1'b0;
        repeat (3) begin
            step();
            check("stall_o_data", o_data_r, 32'h0);
            check("stall_raw_o_data", o_data_w, 32'hC0000000);
            check("stall_o_valid", 32'(o_valid_r), 32'h1);
        end
        i_ready = 1'b1;
        repeat (5) step();
        exp_q = '{32'h3F800000, 32'h00000000, 32'h40400000, 32'h40400000};
        check_vec("stall_relu", got_r, exp_q);
        check_vec("stall_raw", got_w, vec_a);

        // Push during drain sets the sticky overflow and is dropped.
        clear_mon();
        send_vec(vec_b);
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        step();
        i_valid = 1'b0;
        i_data  = 32'h0;
        repeat (5) step();
        check("ovf_set", 32'(o_ovf_r), 32'h1);
        exp_q = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h41000000};
        check_vec("ovf_relu", got_r, exp_q);
        clear_mon();
        send_vec(vec_a);
        repeat (6) step();
        check("ovf_sticky", 32'(o_ovf_r), 32'h1);
        check_vec("ovf_next_raw", got_w, vec_a);
        exp_q = '{32'd2};
        check_vec("ovf_next_class", cls_q, exp_q);

        // Reset mid-vector discards the partial vector.
        i_valid = 1'b1;
        i_data  = 32'h42000000;
        step();
        i_data  = 32'h42800000;
        step();
        i_valid = 1'b0;
        rst_n   = 1'b0;
        step();
        check("rst_ovf_clear", 32'(o_ovf_r), 32'h0);
        check("rst_o_valid", 32'(o_valid_r), 32'h0);
        rst_n = 1'b1;
        step();
        clear_mon();
        send_vec(vec_d);
        check("rst_latency_valid", 32'(o_valid_r), 32'h1);
        check("rst_latency_cv", 32'(o_cv_r), 32'h1);
        repeat (6) step();
        exp_q = '{32'h3F800000, 32'h40A00000, 32'h40000000, 32'h00000000};
        check_vec("rst_relu", got_r, exp_q);
        exp_q = '{32'd1};
        check_vec("rst_class", cls_q, exp_q);

        // Back-to-back vectors with the minimum one-cycle gap.
        clear_mon();
        send_vec(vec_a);
        repeat (4) step();
        send_vec(vec_d);
        repeat (6) step();
        exp_q = '{32'h3F800000, 32'h00000000, 32'h40400000, 32'h40400000,
                  32'h3F800000, 32'h40A00000, 32'h40000000, 32'h00000000};
        check_vec("b2b_relu", got_r, exp_q);
        exp_q = '{32'd2, 32'd1};
        check_vec("b2b_class", cls_q, exp_q);
        exp_q = '{32'd4, 32'd8};
        check_vec("b2b_last", last_q, exp_q);
        check("b2b_no_ovf", 32'(o_ovf_r), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
